// File: rtl/npc_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_alu_pkg
// Description : Shared ALU definitions: multiply op codes, FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_alu_pkg;

   localparam int XLEN = 64;

   localparam logic [3:0] MUL_OP_MUL    = 4'd0;
   localparam logic [3:0] MUL_OP_MULH   = 4'd1;
   localparam logic [3:0] MUL_OP_MULHSU = 4'd2;
   localparam logic [3:0] MUL_OP_MULHU  = 4'd3;
   localparam logic [3:0] MUL_OP_MULW   = 4'd4;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_CALC = 2'd1,
      MUL_FIX  = 2'd2,
      MUL_DONE = 2'd3
   } mul_state_t;

   // Iterations needed; reserved codes fall back to the full 64-bit count.
   function automatic logic [6:0] mul_iter_count(input logic [3:0] op);
      return (op == MUL_OP_MULW) ? 7'd32 : 7'd64;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_if
// Description : Request/response handshake bundle between the EXU and mul_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_seq_if;
   import npc_alu_pkg::*;

   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic [3:0]      control;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result_out;

   modport master (
      output flush, in_valid, src1, src2, control, out_ready,
      input  in_ready, out_valid, result_out
   );

   modport slave (
      input  flush, in_valid, src1, src2, control, out_ready,
      output in_ready, out_valid, result_out
   );

endinterface
`default_nettype wire

// File: rtl/mul_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : mul_sign_fix
// Description : Conditional 128-bit negate of the magnitude product plus
//               per-op result select.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sign_fix
   import npc_alu_pkg::*;
(
   input  wire logic [3:0]        op_i,
   input  wire logic [2*XLEN-1:0] acc_i,
   input  wire logic              neg_i,
   output logic      [XLEN-1:0]   result_o
);

   logic [2*XLEN-1:0] w_prod;

   always_comb begin
      w_prod = neg_i ? -acc_i : acc_i;
      case (op_i)
         MUL_OP_MUL:                               result_o = w_prod[XLEN-1:0];
         MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: result_o = w_prod[2*XLEN-1:XLEN];
         MUL_OP_MULW:                              result_o = {{(XLEN-32){w_prod[31]}}, w_prod[31:0]};
         default:                                  result_o = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq
// Description : Radix-2 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/
//               MULW. Define MUL_SEQ_EARLY_OUT_EN to exit CALC once the
//               remaining multiplier bits are zero. Only XLEN=64 is supported.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
)(
   input wire logic   clk,
   input wire logic   rst,
   mul_seq_if.slave   mul_io
);
   import npc_alu_pkg::*;

   mul_state_t          state_q, state_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     mcand_q, mcand_d;
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          op_q, op_d;
   logic                neg_q, neg_d;

   logic                w_accept, w_calc_exit, w_iterate;
   logic                w_is_w, w_neg_a, w_neg_b;
   logic [XLEN-1:0]     w_a, w_b, w_abs_a, w_abs_b, w_fix_result;
   logic [XLEN:0]       w_sum;
   logic [2*XLEN-1:0]   w_aligned;

   // Operands are reduced to magnitudes; the product sign is applied in FIX.
   always_comb begin
      w_is_w  = (mul_io.control == MUL_OP_MULW);
      w_a     = w_is_w ? {{(XLEN-32){mul_io.src1[31]}}, mul_io.src1[31:0]} : mul_io.src1;
      w_b     = w_is_w ? {{(XLEN-32){mul_io.src2[31]}}, mul_io.src2[31:0]} : mul_io.src2;
      w_neg_a = w_a[XLEN-1] & (w_is_w | (mul_io.control == MUL_OP_MULH) |
                               (mul_io.control == MUL_OP_MULHSU));
      w_neg_b = w_b[XLEN-1] & (w_is_w | (mul_io.control == MUL_OP_MULH));
      w_abs_a = w_neg_a ? -w_a : w_a;
      w_abs_b = w_neg_b ? -w_b : w_b;
   end

   assign w_accept  = (state_q == MUL_IDLE) && mul_io.in_valid && !mul_io.flush;
   assign w_iterate = (state_q == MUL_CALC) && !w_calc_exit;

`ifdef MUL_SEQ_EARLY_OUT_EN
   // The first CALC cycle always iterates; afterwards an exhausted multiplier
   // ends the loop and the unperformed shifts are made up in one step.
   assign w_calc_exit = (cnt_q == '0) ||
                        ((mplier_q == '0) && (cnt_q != CNT_W'(mul_iter_count(op_q))));
   assign w_aligned   = acc_q >> (((op_q == MUL_OP_MULW) ? CNT_W'(32) : CNT_W'(0)) + cnt_q);
`else
   assign w_calc_exit = (cnt_q == '0);
   assign w_aligned   = (op_q == MUL_OP_MULW) ? {32'b0, acc_q[2*XLEN-1:32]} : acc_q;
`endif

   mul_sign_fix u_sign_fix (
      .op_i     (op_q),
      .acc_i    (w_aligned),
      .neg_i    (neg_q),
      .result_o (w_fix_result)
   );

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      result_d = result_q;
      w_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      if (w_accept) begin
         op_d     = mul_io.control;
         mcand_d  = w_abs_a;
         mplier_d = w_abs_b;
         neg_d    = w_neg_a ^ w_neg_b;
         acc_d    = '0;
         cnt_d    = CNT_W'(mul_iter_count(mul_io.control));
      end else if (w_iterate) begin
         acc_d    = {w_sum, acc_q[XLEN-1:1]};
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CNT_W'(1);
      end
      if ((state_q == MUL_FIX) && !mul_io.flush) begin
         result_d = w_fix_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MUL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MUL_IDLE: if (mul_io.in_valid) state_d = MUL_CALC;
         MUL_CALC: if (w_calc_exit)     state_d = MUL_FIX;
         MUL_FIX:                       state_d = MUL_DONE;
         MUL_DONE: if (mul_io.out_ready) state_d = MUL_IDLE;
         default:                       state_d = MUL_IDLE;
      endcase
      if (mul_io.flush) begin
         state_d = MUL_IDLE;
      end
   end

   always_comb begin
      mul_io.in_ready   = (state_q == MUL_IDLE);
      mul_io.out_valid  = (state_q == MUL_DONE);
      mul_io.result_out = result_q;
   end

endmodule
`default_nettype wire
